// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the Random16 word stream: seeds a local generator
// from the stream, locks after a run of correct predictions, then counts mispredicts.
module lfsr_stream_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [15:0] expected
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  // Random16 step; every tap reads the old word.
  function automatic logic [15:0] step16(input logic [15:0] d);
    logic [15:0] n;
    n     = {d[15] ^ d[13] ^ d[12] ^ d[10], d[15:1]};
    n[10] = d[0] ^ d[11];
    n[11] = d[0] ^ d[13];
    n[12] = d[0] ^ d[14];
    return n;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  run_q, run_d, miss_q, miss_d;
  logic [15:0] exp_q, exp_d, cnt_q, cnt_d;
  logic        pulse_d, locked_d;

  logic [15:0] step_in, step_exp;
  logic [3:0]  run_inc, miss_inc;
  logic        hit;

  assign step_in  = step16(in_data);
  assign step_exp = step16(exp_q);
  assign run_inc  = run_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;
  assign hit      = (in_data == exp_q);

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_data != 16'h0000) begin
            exp_d   = step_in;
            run_d   = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            exp_d = step_in;
            run_d = run_inc;
            if (run_inc == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else if (in_data != 16'h0000) begin
            exp_d = step_in;
            run_d = 4'd0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from itself, never from the input.
          exp_d = step_exp;
          if (hit) begin
            miss_d = 4'd0;
          end else begin
            pulse_d = 1'b1;
            miss_d  = miss_inc;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            if (miss_inc == LOSS_N) begin
              run_d = 4'd0;
              if (in_data == 16'h0000) begin
                state_d = HUNT;
              end else begin
                state_d = VERIFY;
                exp_d   = step_in;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clear) cnt_d = 16'h0000;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= HUNT;
      run_q     <= 4'd0;
      miss_q    <= 4'd0;
      exp_q     <= 16'h0000;
      cnt_q     <= 16'h0000;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      err_pulse <= pulse_d;
      locked    <= locked_d;
    end
  end

  assign expected  = exp_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Scoreboard bench for lfsr_stream_checker: a behavioural model queues the
// expected outputs per driven cycle; a second instance covers counter saturation.
`timescale 1ns/1ps
module tb_lfsr_stream_checker;

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic        clock = 1'b0;
  logic        resetn, clear, in_valid;
  logic [15:0] in_data;
  logic        locked, err_pulse;
  logic [15:0] err_count, expected;

  logic        s_resetn, s_clear, s_valid;
  logic [15:0] s_data;
  logic        s_locked, s_pulse;
  logic [15:0] s_count, s_expected;

  always #5 clock = ~clock;

  lfsr_stream_checker dut (
    .clock(clock), .resetn(resetn), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .expected(expected)
  );

  lfsr_stream_checker #(.LOCK_COUNT(4), .LOSS_COUNT(15)) dut_sat (
    .clock(clock), .resetn(s_resetn), .clear(s_clear), .in_valid(s_valid),
    .in_data(s_data), .locked(s_locked), .err_pulse(s_pulse),
    .err_count(s_count), .expected(s_expected)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] rnd_next(input logic [15:0] d);
    logic [15:0] n;
    for (int i = 0; i < 15; i++) n[i] = d[i+1];
    n[15] = d[15] ^ d[13] ^ d[12] ^ d[10];
    n[10] = d[0] ^ d[11];
    n[11] = d[0] ^ d[13];
    n[12] = d[0] ^ d[14];
    return n;
  endfunction

  typedef struct packed {
    logic        lk;
    logic        pl;
    logic [15:0] cnt;
    logic [15:0] ex;
  } obs_t;
  obs_t sb[$];

  // behavioural model: 0 hunt, 1 verify, 2 locked
  int          m_st;
  int          m_run, m_miss;
  logic [15:0] m_exp, m_cnt;
  logic        m_pulse;

  task automatic model_reset();
    m_st = 0; m_run = 0; m_miss = 0; m_exp = 16'h0; m_cnt = 16'h0; m_pulse = 1'b0;
  endtask

  task automatic model_word(input logic v, input logic [15:0] d, input logic c);
    logic [15:0] prev;
    m_pulse = 1'b0;
    if (v) begin
      if (m_st == 0) begin
        if (d != 16'h0) begin m_exp = rnd_next(d); m_run = 0; m_st = 1; end
      end else if (m_st == 1) begin
        if (d == m_exp) begin
          m_exp = rnd_next(d); m_run++;
          if (m_run == LOCK_N) begin m_st = 2; m_miss = 0; end
        end else if (d != 16'h0) begin
          m_exp = rnd_next(d); m_run = 0;
        end else m_st = 0;
      end else begin
        prev  = m_exp;
        m_exp = rnd_next(prev);
        if (d == prev) m_miss = 0;
        else begin
          m_pulse = 1'b1;
          if (m_cnt != 16'hFFFF) m_cnt++;
          m_miss++;
          if (m_miss == LOSS_N) begin
            m_run = 0;
            if (d == 16'h0) m_st = 0;
            else begin m_st = 1; m_exp = rnd_next(d); end
          end
        end
      end
    end
    if (c) m_cnt = 16'h0;
  endtask

  task automatic compare_front();
    obs_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("locked",    locked,    e.lk);
    check("err_pulse", err_pulse, e.pl);
    check("err_count", err_count, e.cnt);
    check("expected",  expected,  e.ex);
  endtask

  task automatic apply(input logic v, input logic [15:0] d, input logic c);
    @(negedge clock);
    in_valid = v; in_data = d; clear = c;
    model_word(v, d, c);
    sb.push_back('{(m_st == 2), m_pulse, m_cnt, m_exp});
    @(posedge clock); #1;
    compare_front();
  endtask

  task automatic do_reset(input logic v, input logic [15:0] d);
    @(negedge clock);
    resetn = 1'b0; in_valid = v; in_data = d; clear = 1'b0;
    model_reset();
    sb.push_back('{1'b0, 1'b0, 16'h0, 16'h0});
    @(posedge clock); #1;
    compare_front();
    @(negedge clock);
    resetn = 1'b1; in_valid = 1'b0;
  endtask

  logic [15:0] g;

  task automatic send_gen(input int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b1, g, 1'b0);
      g = rnd_next(g);
    end
  endtask

  task automatic sat_word(input logic v, input logic [15:0] d, input logic c);
    @(negedge clock);
    s_valid = v; s_data = d; s_clear = c;
    @(posedge clock); #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w3, sg;
    int errs, run;
    resetn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    s_resetn = 1'b0; s_clear = 1'b0; s_valid = 1'b0; s_data = 16'h0;
    model_reset();

    // reset state, including a valid word presented during reset
    do_reset(1'b0, 16'h0);
    do_reset(1'b1, 16'h800D);

    // gap-free generator stream from 0x800D
    g = 16'h800D;
    send_gen(1);
    check("seed_prediction", expected, 16'hDC06);
    send_gen(3);
    check("no_lock_after_4", locked, 1'b0);
    send_gen(1);
    check("lock_after_5", locked, 1'b1);
    send_gen(3);
    apply(1'b0, 16'hFFFF, 1'b0);
    apply(1'b0, 16'h1234, 1'b0);
    send_gen(3);

    // zeros in HUNT are ignored
    do_reset(1'b0, 16'h0);
    repeat (3) apply(1'b1, 16'h0000, 1'b0);
    g = 16'h1234;
    send_gen(4);
    check("zero_hunt_no_lock", locked, 1'b0);
    send_gen(1);
    check("zero_hunt_lock", locked, 1'b1);

    // single flipped bit while locked
    apply(1'b1, g ^ 16'h0008, 1'b0);
    g = rnd_next(g);
    check("single_err_pulse", err_pulse, 1'b1);
    check("single_err_count", err_count, 16'd1);
    check("single_err_locked", locked, 1'b1);
    send_gen(4);

    // three consecutive bad words drop lock
    do_reset(1'b0, 16'h0);
    g = 16'hACE1;
    send_gen(5);
    w3 = 16'h0;
    for (int i = 0; i < 3; i++) begin
      w3 = g ^ 16'h0100;
      apply(1'b1, w3, 1'b0);
      g = rnd_next(g);
    end
    check("loss_count", err_count, 16'd3);
    check("loss_unlocked", locked, 1'b0);
    check("loss_pulse", err_pulse, 1'b1);
    check("loss_reseed", expected, rnd_next(w3));

    // relock from reseed, then clear against a locked mispredict
    g = rnd_next(w3);
    send_gen(4);
    check("relock", locked, 1'b1);
    apply(1'b1, g ^ 16'h0008, 1'b1);
    g = rnd_next(g);
    check("clear_wins_count", err_count, 16'd0);
    check("clear_wins_pulse", err_pulse, 1'b1);

    // err_count=2 then reset during a valid word
    send_gen(1);
    apply(1'b1, g ^ 16'h8000, 1'b0);
    g = rnd_next(g);
    send_gen(1);
    apply(1'b1, g ^ 16'h0002, 1'b0);
    g = rnd_next(g);
    check("pre_reset_count", err_count, 16'd2);
    do_reset(1'b1, g);
    g = 16'h5A5A;
    send_gen(4);
    check("post_reset_no_lock", locked, 1'b0);
    send_gen(1);
    check("post_reset_lock", locked, 1'b1);

    // randomized gaps, corruption, zeros and clears against the model
    for (int i = 0; i < 400; i++) begin
      logic v, c;
      logic [15:0] d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 29) == 0);
      d = g;
      if ($urandom_range(0, 7) == 0) d = g ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) d = 16'h0;
      apply(v, d, c);
      if (v) g = rnd_next(g);
    end

    // saturation on an instance that tolerates 14 consecutive misses
    @(negedge clock); s_resetn = 1'b1;
    sg = 16'h800D;
    for (int i = 0; i < 5; i++) begin sat_word(1'b1, sg, 1'b0); sg = rnd_next(sg); end
    check("sat_locked", s_locked, 1'b1);
    errs = 0; run = 0;
    while (errs < 65535) begin
      if (run == 14) begin
        sat_word(1'b1, sg, 1'b0);
        run = 0;
      end else begin
        sat_word(1'b1, sg ^ 16'h0008, 1'b0);
        errs++; run++;
      end
      sg = rnd_next(sg);
    end
    check("sat_full", s_count, 16'hFFFF);
    check("sat_still_locked", s_locked, 1'b1);
    sat_word(1'b1, sg, 1'b0); sg = rnd_next(sg);
    sat_word(1'b1, sg ^ 16'h0008, 1'b0); sg = rnd_next(sg);
    check("sat_hold", s_count, 16'hFFFF);
    check("sat_hold_pulse", s_pulse, 1'b1);
    sat_word(1'b1, sg ^ 16'h0008, 1'b1); sg = rnd_next(sg);
    check("sat_clear_count", s_count, 16'h0000);
    check("sat_clear_pulse", s_pulse, 1'b1);
    sat_word(1'b0, 16'h0, 1'b0);
    check("sat_idle_pulse", s_pulse, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Receive-side checker for the 16-bit pseudo-random word stream produced by the team's Random16 generator. It accepts words with a valid strobe, seeds its own copy of the generator from the stream, and locks after a run of consecutive correct predictions. Once locked, it flags and counts every word that differs from the prediction. It sits on the receive end of any random-stream link, e.g. a mutation-engine input or board-to-board RNG share, for link integrity and sequence-sync checking.

## Interface
- LOCK_COUNT, 4: consecutive correct predictions required to lock (range 1–15).
- LOSS_COUNT, 3: consecutive mispredictions while locked that drop lock (range 1–15).
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  reset, synchronous, active-low; clock clock.
- clear  in  1  synchronous clear of err_count only.
- in_valid  in  1  in_data is a stream word this cycle.
- in_data  in  16  received stream word.
- locked  out  1  registered; high while in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse per locked mispredict.
- err_count  out  16  registered, saturating count of locked mispredicts.
- expected  out  16  registered; predicted value of the next word.

## Operation
- Step function S(d), identical to the generator. All terms use the old d.
  - fb = d15^d13^d12^d10
  - n = {fb, d[15:1]}
  - n[10] = d0^d11; n[11] = d0^d13; n[12] = d0^d14
- Reference point: S(0x800D)=0xDC06. S(0)=0, so 0x0000 is never a valid seed.
- States: HUNT, VERIFY, LOCKED. Internal counters are 4-bit: run (matches) and miss (mispredicts).
- Words are processed only in cycles with in_valid=1. With in_valid=0 there is no state or counter change and err_pulse=0.
- HUNT:
  - Word 0x0000: ignored.
  - Any other word w: expected<=S(w), run<=0, go to VERIFY.
- VERIFY, word w:
  - w==expected: expected<=S(w) and run<=run+1. If run+1==LOCK_COUNT, go to LOCKED with miss<=0.
  - w!=expected and w!=0: reseed with expected<=S(w), run<=0, stay in VERIFY.
  - w!=expected and w==0: go to HUNT.
  - No error is reported in VERIFY.
- LOCKED, word w. The checker flywheels: expected<=S(expected) in both cases below and never reseeds from input while locked.
  - w==expected: miss<=0.
  - w!=expected: err_pulse<=1, err_count increments (saturating at 0xFFFF), miss<=miss+1.
  - If miss+1==LOSS_COUNT: go to VERIFY with expected<=S(w) (or go to HUNT if w==0), run<=0.
- Simultaneous clear and counted error: clear wins, err_count=0.
- locked == (state==LOCKED).

## Timing
- Reset values: state HUNT, locked=0, err_pulse=0, err_count=0x0000, expected=0x0000, run=0, miss=0.
- Reset takes priority over every other input, including mid-lock and mid-clear.
- Latency: all outputs reflect word k in the cycle after its in_valid edge. There is no combinational path from any input to any output.
- Back-to-back valids are supported at one word per clock. Gaps of any length are allowed, and prediction resumes on the next valid word.
- Lock: with seed at valid word 0, locked rises the cycle after valid word LOCK_COUNT (gap-free default: 5 clocks after the seed edge).
- Loss: locked falls the cycle after the LOSS_COUNT-th consecutive locked mispredict. err_pulse is high in that same cycle.
- err_pulse is never high for two cycles from one word. Consecutive bad words give consecutive pulses.

## Test plan
- Reset, then stream the generator sequence 0x800D, 0xDC06, … gap-free. Required: locked=1 one cycle after the 5th word, err_count=0 throughout, expected=S(last word).
- In HUNT, send 0x0000 three times, then the sequence. Required: the zeros are ignored, locked stays 0, and lock occurs after the 5th nonzero word.
- Locked, one word with bit 3 flipped, then correct words. Required: one err_pulse, err_count=1, locked stays 1, and the following correct words match with no further pulse.
- Locked, three consecutive corrupted words. Required: err_count=3, locked=0 the cycle after the 3rd, state VERIFY with expected=S(3rd word).
- err_count preloaded to 0xFFFF by a long error run, then another mispredict. Required: err_count stays 0xFFFF. Next, clear asserted in the same cycle as a locked mispredict. Required: err_count=0 and err_pulse=1.
- Locked with err_count=2; assert resetn=0 for one cycle during a valid word. Required: locked=0, err_count=0, expected=0, and relock needs a full seed plus 4 matches.
